// File: rtl/random_event_sched.sv
// Random pet-event scheduler: turns an LFSR byte stream into randomly spaced, randomly typed events.
// Optional weighted event types are enabled with `define RAND_EVT_WEIGHT_EN.
module random_event_sched #(
  parameter int MIN_INTERVAL = 8,
  parameter int RAND_BITS    = 5,
  parameter int MISS_W       = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              tick_in,
  input  logic [7:0]        rand_in,
  output logic              event_valid,
  input  logic              event_ready,
  output logic [1:0]        event_type,
  output logic [7:0]        countdown,
  output logic [MISS_W-1:0] missed_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    COUNT = 2'd2
  } state_t;

  state_t state;
  logic   handshake;
  logic   expiry;

  localparam logic [7:0] RAND_MASK = 8'((1 << RAND_BITS) - 1);
  localparam logic [7:0] MIN_IVL   = 8'(MIN_INTERVAL);

  function automatic logic [7:0] interval_of(input logic [7:0] r);
    return MIN_IVL + (r & RAND_MASK);
  endfunction

  function automatic logic [1:0] type_of(input logic [7:0] r);
`ifdef RAND_EVT_WEIGHT_EN
    case (r[7:5])
      3'd0, 3'd1, 3'd2, 3'd3: return 2'd0;
      3'd4, 3'd5:             return 2'd1;
      3'd6:                   return 2'd2;
      default:                return 2'd3;
    endcase
`else
    return r[7:6];
`endif
  endfunction

  function automatic logic [MISS_W-1:0] sat_inc(input logic [MISS_W-1:0] v);
    return (&v) ? v : v + {{(MISS_W-1){1'b0}}, 1'b1};
  endfunction

  assign handshake = event_valid & event_ready;
  // Expiry only counts while enabled; dropping enable wins over a coincident final tick.
  assign expiry    = (state == COUNT) & enable & tick_in & (countdown == 8'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      event_valid <= 1'b0;
      event_type  <= 2'd0;
      countdown   <= 8'd0;
      missed_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) state <= LOAD;
        end
        LOAD: begin
          if (!enable) begin
            state     <= IDLE;
            countdown <= 8'd0;
          end else begin
            countdown <= interval_of(rand_in);
            state     <= COUNT;
          end
        end
        COUNT: begin
          if (!enable) begin
            state     <= IDLE;
            countdown <= 8'd0;
          end else if (tick_in) begin
            countdown <= countdown - 8'd1;
            if (countdown == 8'd1) state <= LOAD;
          end
        end
        default: begin
          state     <= IDLE;
          countdown <= 8'd0;
        end
      endcase

      // A consumed slot can be refilled in the same clock; otherwise a new expiry is dropped.
      if (expiry) begin
        if (!event_valid || event_ready) begin
          event_valid <= 1'b1;
          event_type  <= type_of(rand_in);
        end else begin
          missed_cnt <= sat_inc(missed_cnt);
        end
      end else if (handshake) begin
        event_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/random_event_sched.md
Name: random_event_sched

Overview:
- Consumes the 8-bit pseudo-random stream from the LFSR generator.
- Turns it into randomly spaced, randomly typed pet events: hunger, boredom, sickness and mess.
- Events go to the game-logic FSM over a valid/ready handshake.
- Interval spacing is in game ticks (tick_in pulses), not clocks.

Parameters:
- MIN_INTERVAL, 8: minimum ticks between events; legal range 1..(256 - 2^RAND_BITS).
- RAND_BITS, 5: number of low random bits added to MIN_INTERVAL; legal range 1..7.
- MISS_W, 4: width of the saturating missed-event counter.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- enable  in  1  scheduler run enable (level)
- tick_in  in  1  one-clock game tick pulse
- rand_in  in  8  random byte from the LFSR generator, sampled, never held
- event_valid  out  1  event pending
- event_ready  in  1  consumer accepts the event
- event_type  out  2  0=hunger, 1=boredom, 2=sick, 3=mess; stable while event_valid
- countdown  out  8  ticks remaining to the next expiry (debug/UI)
- missed_cnt  out  MISS_W  events lost because a previous one was still pending

Behaviour:
- Reset (rst low, async) values:
  - state=IDLE
  - event_valid=0, event_type=0, countdown=0, missed_cnt=0
- Interval: interval = MIN_INTERVAL + (rand_in & (2^RAND_BITS-1)), 8-bit unsigned. No overflow, given the parameter limits.
- States:
  - IDLE: enable=0. Counter frozen. On enable=1, go to LOAD next clock.
  - LOAD (one clock): countdown <= interval from current rand_in, then go to COUNT.
  - COUNT: each clock with tick_in=1, countdown decrements.
    - If tick_in=1 and countdown==1 ("expiry"): capture event_type <= rand_in[7:6], assert event_valid next clock, go to LOAD.
    - The rand_in sampled in LOAD is one clock later than the type sample, so it is a different LFSR value.
  - event_valid is independent of state: it is held until a clock with event_valid & event_ready, then deasserts next clock.
- Expiry while event_valid=1 and event_ready=0:
  - The pending event and its type are retained.
  - The new event is dropped.
  - missed_cnt increments, saturating at 2^MISS_W-1.
- Expiry in the same clock as a handshake: the old event is consumed and the new one takes its place. event_valid stays 1, event_type updates, missed_cnt is unchanged.
- enable falling:
  - From LOAD/COUNT: go to IDLE next clock, and countdown is cleared to 0.
  - A pending event stays valid until accepted.
  - missed_cnt persists.
- enable=1 and tick_in=1 in LOAD: the tick is ignored; no decrement that clock.
- event_ready without event_valid has no effect.
- countdown never wraps. COUNT is never entered with 0.
- Mid-operation reset returns everything to reset values immediately, including a pending event.

Optional Feature:
- Macro: RAND_EVT_WEIGHT_EN.
- Defined: event_type is weighted from rand_in[7:5]:
  - 0-3 -> 0 (hunger)
  - 4-5 -> 1 (boredom)
  - 6 -> 2 (sick)
  - 7 -> 3 (mess)
- Not defined: event_type = rand_in[7:6] (uniform).
- Interval logic is identical in both builds.

Test Plan:
1. Reset, enable=1, rand_in=0x03 at LOAD -> countdown=11. After 11 tick_in pulses, event_valid=1 one clock after the 11th tick, with event_type=rand_in[7:6] at that tick. Hold rand_in=0xC3 -> type=3 (unweighted) or 2 (weighted, 0xC3[7:5]=6).
2. rand_in=0xFF at LOAD with RAND_BITS=5 -> countdown=39. Check exact 39-tick spacing; ticks during LOAD do not decrement.
3. event_ready held 0 across 3 further expiries -> event_valid stays 1, event_type is the original, missed_cnt=3. With MISS_W=4 and 20 expiries, missed_cnt saturates at 15.
4. event_ready=1 in the same clock as an expiry with a pending event -> event_valid stays 1, event_type becomes the new type, missed_cnt unchanged.
5. enable dropped with countdown=5 and an event pending -> next clock IDLE, countdown=0, event_valid still 1 until ready. Re-enable -> LOAD then a fresh interval.
6. rst pulsed low asynchronously mid-COUNT with event_valid=1 -> all outputs 0 without waiting for a clock edge. Operation resumes from IDLE/LOAD after release.
